instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  request valid.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-005 SHALL have port: in_op  input  5  encode opcode (table REQ-012).
REQ-006 SHALL have ports: in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-007 SHALL have port: in_imm  input  32  immediate / offset / shamt / target / sel.
REQ-008 SHALL have port: out_valid  output  1  encoded word valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-010 SHALL have ports: out_instr  output  32  MIPS32 word; out_last  output  1  final word of a request.
REQ-011 SHALL have port: err_unsupported  output  1  one-cycle pulse when an accepted in_op is unsupported.

Function
REQ-012 in_op table SHALL be: 0 NOP, 1 ADDU, 2 SUBU, 3 AND, 4 OR, 5 SLL, 6 JR, 7 ADDIU, 8 ORI, 9 LUI, 10 BEQ, 11 BNE, 12 LW, 13 SW, 14 J, 15 JAL, 16 MFC0, 17 MTC0, 18 ERET, 19 SYSCALL, 20 BREAK, 21 LI (pseudo); 22-31 unsupported.
REQ-013 R-type SHALL be {000000,rs,rt,rd,00000,funct}: ADDU 100001, SUBU 100011, AND 100100, OR 100101; NOP = 0x00000000.
REQ-014 SLL SHALL be {000000,00000,rt,rd,imm[4:0],000000}; JR SHALL be {000000,rs,15'b0,001000}.
REQ-015 I-type SHALL be {op,rs,rt,imm[15:0]}: ADDIU 001001, ORI 001101, LUI 001111 (rs forced 0), BEQ 000100, BNE 000101, LW 100011, SW 101011; branch imm is a word offset, used as-is.
REQ-016 J/JAL SHALL be {000010/000011, imm[27:2]}.
REQ-017 MFC0/MTC0 SHALL be {010000, 00000/00100, rt, rd, 8'b0, imm[2:0]}; ERET 0x42000018, SYSCALL 0x0000000C, BREAK 0x0000000D.
REQ-018 LI SHALL expand: imm[31:16]==0 -> ORI rt,$0,imm[15:0] (1 word); imm[15:0]==0 -> LUI rt,imm[31:16] (1 word); else LUI rt,imm[31:16] then ORI rt,rt,imm[15:0] (2 words).
REQ-019 FSM SHALL have states EMPTY (no word held), HOLD1 (holding last/only word), HOLD2 (holding first of two words, second buffered).
REQ-020 in_ready SHALL equal (state==EMPTY) || (state==HOLD1 && out_ready); never high in HOLD2.
REQ-021 Accepted supported request SHALL present its first word on out_valid the next cycle (latency 1); single-word ops back-to-back SHALL sustain 1 word/cycle.
REQ-022 HOLD2 with out_ready SHALL move the second word into out_instr next cycle, state HOLD1, out_last=1; out_last=0 while in HOLD2.
REQ-023 While out_valid && !out_ready, out_instr and out_last SHALL hold stable.
REQ-024 Unsupported op SHALL be accepted and dropped: no word emitted, err_unsupported=1 next cycle only, state EMPTY unless a held word remains.
REQ-025 Unused register fields for an op SHALL be ignored (encoded as zero where the format fixes them).

Reset
REQ-026 On reset SHALL set state EMPTY, out_valid=0, out_last=0, out_instr=0, err_unsupported=0; reset mid-expansion SHALL discard the buffered second word.
REQ-027 in_ready SHALL be 0 during the reset cycle and 1 the cycle after.

Configuration
REQ-028 Macro ENCODER_PSEUDO_EN SHALL, when defined, enable in_op 21 (LI) expansion and state HOLD2.
REQ-029 Without ENCODER_PSEUDO_EN, in_op 21 SHALL be treated as unsupported (REQ-024) and out_last SHALL be constant 1 whenever out_valid.

Verification
REQ-030 ADDU rd=3 rs=1 rt=2, out_ready=1 -> next cycle out_instr=0x00221821, out_last=1.
REQ-031 LW rt=8 rs=29 imm=0x10 -> out_instr=0x8FA80010; ERET -> 0x42000018.
REQ-032 LI rt=4 imm=0x12345678 (PSEUDO_EN) -> 0x3C041234 out_last=0, then 0x34845678 out_last=1; in_ready low during first word.
REQ-033 LI rt=4 imm=0x00005678 -> single 0x34045678; imm=0x12340000 -> single 0x3C041234.
REQ-034 out_ready held 0 for 3 cycles after SUBU issue -> out_instr stable, in_ready=0, no second request accepted; release -> word consumed, next request accepted same cycle.
REQ-035 in_op=25 -> err_unsupported pulses 1 cycle, out_valid stays 0; reset asserted in HOLD2 -> out_valid=0 next cycle, second word never emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS32 instruction encoder: turns an opcode/field request into one (or, for LI, two)
// 32-bit words behind a valid/ready skid stage. Define ENCODER_PSEUDO_EN to enable LI expansion.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err_unsupported
);

    localparam logic [4:0] OP_NOP     = 5'd0;
    localparam logic [4:0] OP_ADDU    = 5'd1;
    localparam logic [4:0] OP_SUBU    = 5'd2;
    localparam logic [4:0] OP_AND     = 5'd3;
    localparam logic [4:0] OP_OR      = 5'd4;
    localparam logic [4:0] OP_SLL     = 5'd5;
    localparam logic [4:0] OP_JR      = 5'd6;
    localparam logic [4:0] OP_ADDIU   = 5'd7;
    localparam logic [4:0] OP_ORI     = 5'd8;
    localparam logic [4:0] OP_LUI     = 5'd9;
    localparam logic [4:0] OP_BEQ     = 5'd10;
    localparam logic [4:0] OP_BNE     = 5'd11;
    localparam logic [4:0] OP_LW      = 5'd12;
    localparam logic [4:0] OP_SW      = 5'd13;
    localparam logic [4:0] OP_J       = 5'd14;
    localparam logic [4:0] OP_JAL     = 5'd15;
    localparam logic [4:0] OP_MFC0    = 5'd16;
    localparam logic [4:0] OP_MTC0    = 5'd17;
    localparam logic [4:0] OP_ERET    = 5'd18;
    localparam logic [4:0] OP_SYSCALL = 5'd19;
    localparam logic [4:0] OP_BREAK   = 5'd20;
    localparam logic [4:0] OP_LI      = 5'd21;

    localparam logic [5:0] MOP_SPECIAL = 6'b000000;
    localparam logic [5:0] MOP_J       = 6'b000010;
    localparam logic [5:0] MOP_JAL     = 6'b000011;
    localparam logic [5:0] MOP_BEQ     = 6'b000100;
    localparam logic [5:0] MOP_BNE     = 6'b000101;
    localparam logic [5:0] MOP_ADDIU   = 6'b001001;
    localparam logic [5:0] MOP_ORI     = 6'b001101;
    localparam logic [5:0] MOP_LUI     = 6'b001111;
    localparam logic [5:0] MOP_COP0    = 6'b010000;
    localparam logic [5:0] MOP_LW      = 6'b100011;
    localparam logic [5:0] MOP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [31:0] enc_word0;
    logic        enc_ok;
    logic        accept;
    logic        load;

`ifdef ENCODER_PSEUDO_EN
    logic [31:0] second_q, second_d;
    logic [31:0] enc_word1;
    logic        enc_two;
`endif

    // Upper immediate nibble only matters to LI; keep it visibly consumed in all builds.
    logic unused_imm_bits;
    assign unused_imm_bits = ^in_imm[31:28];

    always_comb begin
        enc_word0 = '0;
        enc_ok    = 1'b1;
`ifdef ENCODER_PSEUDO_EN
        enc_word1 = '0;
        enc_two   = 1'b0;
`endif
        case (in_op)
            OP_NOP:     enc_word0 = '0;
            OP_ADDU:    enc_word0 = {MOP_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_ADDU};
            OP_SUBU:    enc_word0 = {MOP_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_SUBU};
            OP_AND:     enc_word0 = {MOP_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_AND};
            OP_OR:      enc_word0 = {MOP_SPECIAL, in_rs, in_rt, in_rd, 5'd0, FN_OR};
            OP_SLL:     enc_word0 = {MOP_SPECIAL, 5'd0, in_rt, in_rd, in_imm[4:0], FN_SLL};
            OP_JR:      enc_word0 = {MOP_SPECIAL, in_rs, 15'd0, FN_JR};
            OP_ADDIU:   enc_word0 = {MOP_ADDIU, in_rs, in_rt, in_imm[15:0]};
            OP_ORI:     enc_word0 = {MOP_ORI, in_rs, in_rt, in_imm[15:0]};
            OP_LUI:     enc_word0 = {MOP_LUI, 5'd0, in_rt, in_imm[15:0]};
            OP_BEQ:     enc_word0 = {MOP_BEQ, in_rs, in_rt, in_imm[15:0]};
            OP_BNE:     enc_word0 = {MOP_BNE, in_rs, in_rt, in_imm[15:0]};
            OP_LW:      enc_word0 = {MOP_LW, in_rs, in_rt, in_imm[15:0]};
            OP_SW:      enc_word0 = {MOP_SW, in_rs, in_rt, in_imm[15:0]};
            OP_J:       enc_word0 = {MOP_J, in_imm[27:2]};
            OP_JAL:     enc_word0 = {MOP_JAL, in_imm[27:2]};
            OP_MFC0:    enc_word0 = {MOP_COP0, 5'b00000, in_rt, in_rd, 8'd0, in_imm[2:0]};
            OP_MTC0:    enc_word0 = {MOP_COP0, 5'b00100, in_rt, in_rd, 8'd0, in_imm[2:0]};
            OP_ERET:    enc_word0 = 32'h4200_0018;
            OP_SYSCALL: enc_word0 = 32'h0000_000C;
            OP_BREAK:   enc_word0 = 32'h0000_000D;
`ifdef ENCODER_PSEUDO_EN
            OP_LI: begin
                // Pick the shortest sequence that materialises the 32-bit constant.
                if (in_imm[31:16] == 16'd0) begin
                    enc_word0 = {MOP_ORI, 5'd0, in_rt, in_imm[15:0]};
                end else if (in_imm[15:0] == 16'd0) begin
                    enc_word0 = {MOP_LUI, 5'd0, in_rt, in_imm[31:16]};
                end else begin
                    enc_word0 = {MOP_LUI, 5'd0, in_rt, in_imm[31:16]};
                    enc_word1 = {MOP_ORI, in_rt, in_rt, in_imm[15:0]};
                    enc_two   = 1'b1;
                end
            end
`endif
            default:    enc_ok = 1'b0;
        endcase
    end

    assign in_ready  = !reset && ((state_q == EMPTY) || ((state_q == HOLD1) && out_ready));
    assign accept    = in_valid && in_ready;
    assign load      = accept && enc_ok;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        err_d    = accept && !enc_ok;
`ifdef ENCODER_PSEUDO_EN
        second_d = second_q;
`endif
        case (state_q)
            EMPTY, HOLD1: begin
                if (load) begin
                    instr_d = enc_word0;
`ifdef ENCODER_PSEUDO_EN
                    second_d = enc_word1;
                    state_d  = enc_two ? HOLD2 : HOLD1;
`else
                    state_d  = HOLD1;
`endif
                end else if ((state_q == HOLD1) && out_ready) begin
                    state_d = EMPTY;
                end
            end
`ifdef ENCODER_PSEUDO_EN
            HOLD2: begin
                if (out_ready) begin
                    instr_d = second_q;
                    state_d = HOLD1;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            instr_q  <= '0;
            err_q    <= 1'b0;
`ifdef ENCODER_PSEUDO_EN
            second_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
`ifdef ENCODER_PSEUDO_EN
            second_q <= second_d;
`endif
        end
    end

    assign out_valid       = (state_q != EMPTY);
    assign out_last        = (state_q == HOLD1);
    assign out_instr       = instr_q;
    assign err_unsupported = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written stall/reset
// sequences, then randomized traffic against a word-queue reference model.
module tb_instr_encoder;

`ifdef ENCODER_PSEUDO_EN
    localparam bit PSEUDO = 1'b1;
`else
    localparam bit PSEUDO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err_unsupported;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_rs           (in_rs),
        .in_rt           (in_rt),
        .in_rd           (in_rd),
        .in_imm          (in_imm),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_last        (out_last),
        .err_unsupported (err_unsupported)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } word_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [31:0] op6, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] imm16);
        return (op6 << 26) | (rs << 21) | (rt << 16) | (imm16 & 32'hFFFF);
    endfunction

    function automatic logic [31:0] rtype(input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [31:0] rd, input logic [31:0] sh,
                                          input logic [31:0] fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | ((sh % 32) << 6) | fn;
    endfunction

    // Reference: number of words a request produces (0 = unsupported) and their values.
    function automatic void ref_encode(input logic [4:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [31:0] imm, output int n,
                                       output logic [31:0] w0, output logic [31:0] w1);
        logic [31:0] hi, lo;
        n  = 1;
        w0 = 0;
        w1 = 0;
        hi = imm >> 16;
        lo = imm & 32'hFFFF;
        case (op)
            0:  w0 = 0;
            1:  w0 = rtype(rs, rt, rd, 0, 33);
            2:  w0 = rtype(rs, rt, rd, 0, 35);
            3:  w0 = rtype(rs, rt, rd, 0, 36);
            4:  w0 = rtype(rs, rt, rd, 0, 37);
            5:  w0 = rtype(0, rt, rd, imm, 0);
            6:  w0 = rtype(rs, 0, 0, 0, 8);
            7:  w0 = itype(9, rs, rt, imm);
            8:  w0 = itype(13, rs, rt, imm);
            9:  w0 = itype(15, 0, rt, imm);
            10: w0 = itype(4, rs, rt, imm);
            11: w0 = itype(5, rs, rt, imm);
            12: w0 = itype(35, rs, rt, imm);
            13: w0 = itype(43, rs, rt, imm);
            14: w0 = (32'd2 << 26) | ((imm >> 2) & 32'h03FF_FFFF);
            15: w0 = (32'd3 << 26) | ((imm >> 2) & 32'h03FF_FFFF);
            16: w0 = (32'd16 << 26) | (32'(rt) << 16) | (32'(rd) << 11) | (imm & 7);
            17: w0 = (32'd16 << 26) | (32'd4 << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (imm & 7);
            18: w0 = 32'h4200_0018;
            19: w0 = 12;
            20: w0 = 13;
            21: begin
                if (!PSEUDO)      n = 0;
                else if (hi == 0) w0 = itype(13, 0, rt, lo);
                else if (lo == 0) w0 = itype(15, 0, rt, hi);
                else begin
                    n  = 2;
                    w0 = itype(15, 0, rt, hi);
                    w1 = itype(13, rt, rt, lo);
                end
            end
            default: n = 0;
        endcase
    endfunction

    task automatic drive_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_valid = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        int waited;
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(v.op, v.rs, v.rt, v.rd, v.imm);
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) chk({v.name, "_ready_timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v.n == 0) begin
            chk({v.name, "_err"}, 32'(err_unsupported), 32'd1);
            chk({v.name, "_novalid"}, 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            chk({v.name, "_err_clear"}, 32'(err_unsupported), 32'd0);
        end else begin
            chk({v.name, "_valid"}, 32'(out_valid), 32'd1);
            chk({v.name, "_w0"}, out_instr, v.w0);
            chk({v.name, "_last0"}, 32'(out_last), (v.n == 1) ? 32'd1 : 32'd0);
            if (v.n == 2) begin
                chk({v.name, "_busy"}, 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                chk({v.name, "_w1"}, out_instr, v.w1);
                chk({v.name, "_last1"}, 32'(out_last), 32'd1);
            end
            @(posedge clk);
            #1;
            chk({v.name, "_idle"}, 32'(out_valid), 32'd0);
        end
        $display("vec %-10s op=%0d words=%0d out=%h", v.name, v.op, v.n, out_instr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[18];
        word_t q[$];
        logic  exp_err;
        int    n;
        logic [31:0] w0, w1;
        bit    exp_ready, acc, cons;

        vecs[0]  = '{"addu",    5'd1,  5'd1,  5'd2,  5'd3,  32'h0,         1, 32'h0022_1821, 32'h0};
        vecs[1]  = '{"subu",    5'd2,  5'd4,  5'd5,  5'd6,  32'hFFFF_FFFF, 1, 32'h0085_3023, 32'h0};
        vecs[2]  = '{"lw",      5'd12, 5'd29, 5'd8,  5'd31, 32'h10,        1, 32'h8FA8_0010, 32'h0};
        vecs[3]  = '{"eret",    5'd18, 5'd3,  5'd3,  5'd3,  32'h1234,      1, 32'h4200_0018, 32'h0};
        vecs[4]  = '{"sll",     5'd5,  5'd7,  5'd2,  5'd3,  32'hFFFF_FFE4, 1, 32'h0002_1900, 32'h0};
        vecs[5]  = '{"jr",      5'd6,  5'd31, 5'd5,  5'd5,  32'h0,         1, 32'h03E0_0008, 32'h0};
        vecs[6]  = '{"lui",     5'd9,  5'd7,  5'd4,  5'd0,  32'h1234,      1, 32'h3C04_1234, 32'h0};
        vecs[7]  = '{"beq",     5'd10, 5'd1,  5'd2,  5'd0,  32'hFFFF,      1, 32'h1022_FFFF, 32'h0};
        vecs[8]  = '{"j",       5'd14, 5'd0,  5'd0,  5'd0,  32'h0040_0000, 1, 32'h0810_0000, 32'h0};
        vecs[9]  = '{"jal",     5'd15, 5'd9,  5'd9,  5'd9,  32'h0FFF_FFFC, 1, 32'h0FFF_FFFF, 32'h0};
        vecs[10] = '{"mtc0",    5'd17, 5'd1,  5'd8,  5'd12, 32'h0,         1, 32'h4088_6000, 32'h0};
        vecs[11] = '{"nop",     5'd0,  5'd9,  5'd9,  5'd9,  32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h0};
        vecs[12] = '{"syscall", 5'd19, 5'd0,  5'd0,  5'd0,  32'h0,         1, 32'h0000_000C, 32'h0};
        vecs[13] = '{"unsup25", 5'd25, 5'd1,  5'd2,  5'd3,  32'h0,         0, 32'h0,         32'h0};
        vecs[14] = '{"unsup31", 5'd31, 5'd0,  5'd0,  5'd0,  32'h0,         0, 32'h0,         32'h0};
        vecs[15] = '{"li_two",  5'd21, 5'd0,  5'd4,  5'd0,  32'h1234_5678,
                     PSEUDO ? 2 : 0, 32'h3C04_1234, 32'h3484_5678};
        vecs[16] = '{"li_lo",   5'd21, 5'd0,  5'd4,  5'd0,  32'h0000_5678,
                     PSEUDO ? 1 : 0, 32'h3404_5678, 32'h0};
        vecs[17] = '{"li_hi",   5'd21, 5'd0,  5'd4,  5'd0,  32'h1234_0000,
                     PSEUDO ? 1 : 0, 32'h3C04_1234, 32'h0};

        // Reset state and in_ready behaviour around reset release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", 32'(err_unsupported), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Output backpressure: word stays put and a waiting request is held off.
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(5'd2, 5'd4, 5'd5, 5'd6, 32'h0);
        @(posedge clk);
        #1;
        drive_req(5'd1, 5'd1, 5'd2, 5'd3, 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, 32'h0085_3023);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_next_instr", out_instr, 32'h0022_1821);
        chk("release_next_last", 32'(out_last), 32'd1);
        @(posedge clk);
        #1;
        chk("release_idle", 32'(out_valid), 32'd0);
        $display("seq stall: subu held 3 cycles, addu accepted on release");

        // Reset while the first LI word is stalled: the buffered second word must vanish.
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(5'd21, 5'd0, 5'd4, 5'd0, 32'h1234_5678);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("li_stall_valid", 32'(out_valid), 32'(PSEUDO));
        chk("li_stall_err", 32'(err_unsupported), 32'(!PSEUDO));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_instr", out_instr, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_second", 32'(out_valid), 32'd0);
        end
        $display("seq reset_in_hold: second word discarded");

        // Randomized traffic against the word-queue model.
        exp_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            chk("rnd_err", 32'(err_unsupported), 32'(exp_err));
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_instr", out_instr, q[0].w);
                chk("rnd_last", 32'(out_last), 32'(q[0].last));
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31))
                                                    : 5'($urandom_range(0, 21));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom & 32'h0000_FFFF;
                1:       in_imm = $urandom & 32'hFFFF_0000;
                default: in_imm = $urandom;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            acc  = in_valid && exp_ready;
            cons = (q.size() != 0) && out_ready;
            ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, n, w0, w1);
            @(posedge clk);
            if (cons) void'(q.pop_front());
            exp_err = acc && (n == 0);
            if (acc && n >= 1) q.push_back('{w0, (n == 1)});
            if (acc && n == 2) q.push_back('{w1, 1'b1});
            if (acc) $display("rnd cyc=%0d op=%0d imm=%h words=%0d", cyc, in_op, in_imm, n);
        end

        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
